// File: rtl/if_mem_responder.sv
// Instruction-fetch responder: serves 32-bit words from byte-wide RAM through a
// direct-mapped one-word-per-line cache; misses are filled with a pipelined 4-byte read.
module if_mem_responder #(
   parameter int ADDR_W = 17,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              nd_ins,
   input  logic [31:0]       pc_fetch,
   input  logic              jal_reset,
   output logic              flg_get,
   output logic [31:0]       ins_out,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_a,
   input  logic [7:0]        ram_din
);

   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam int LINES = 1 << IDX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic [2:0]          cnt_r;
   logic [ADDR_W-1:0]   wa_r;
   logic [23:0]         buf_r;
   logic [LINES-1:0]    valid_r;
   logic [31:0]         data_mem [LINES];
   logic [TAG_W-1:0]    tag_mem  [LINES];

   logic [ADDR_W-1:0]   req_wa_s;
   logic [IDX_W-1:0]    req_idx_s;
   logic [TAG_W-1:0]    req_tag_s;
   logic                hit_s;
   logic [IDX_W-1:0]    fill_idx_s;
   logic [TAG_W-1:0]    fill_tag_s;
   logic [31:0]         fill_word_s;
   logic                fill_done_s;
   logic [ADDR_W-1:0]   next_a_s;
   logic                unused_s;

   // Request decode, hit detection and fill-completion strobe.
   always_comb begin
      req_wa_s    = {pc_fetch[ADDR_W-1:2], 2'b00};
      req_idx_s   = pc_fetch[IDX_W+1:2];
      req_tag_s   = pc_fetch[ADDR_W-1:IDX_W+2];
      hit_s       = valid_r[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s);
      fill_idx_s  = wa_r[IDX_W+1:2];
      fill_tag_s  = wa_r[ADDR_W-1:IDX_W+2];
      fill_word_s = {ram_din, buf_r};
      next_a_s    = wa_r + {{(ADDR_W-3){1'b0}}, cnt_r + 3'd1};
      if (state_r == FILL && cnt_r == 3'd4 && rdy && !jal_reset) begin
         fill_done_s = 1'b1;
      end else begin
         fill_done_s = 1'b0;
      end
   end

   assign unused_s = ^{pc_fetch[31:ADDR_W], pc_fetch[1:0]};

   // Line storage; only valid bits need a reset value.
   always_ff @(posedge clk) begin
      if (fill_done_s) begin
         data_mem[fill_idx_s] <= fill_word_s;
         tag_mem[fill_idx_s]  <= fill_tag_s;
      end
   end

   // Valid bits are cleared only by reset and set when a fill completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r <= {LINES{1'b0}};
      end else if (fill_done_s) begin
         valid_r[fill_idx_s] <= 1'b1;
      end
   end

   // Control FSM with registered outputs; rdy low outranks jal_reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= 3'd0;
         wa_r      <= {ADDR_W{1'b0}};
         buf_r     <= 24'd0;
         flg_get   <= 1'b0;
         ins_out   <= 32'd0;
         ram_rd_en <= 1'b0;
         ram_a     <= {ADDR_W{1'b0}};
      end else begin
         flg_get <= 1'b0;
         if (!rdy) begin
            if (state_r == FILL) begin
               cnt_r     <= 3'd0;
               ram_rd_en <= 1'b0;
            end
         end else if (jal_reset) begin
            state_r   <= IDLE;
            cnt_r     <= 3'd0;
            ram_rd_en <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (nd_ins) begin
                     if (hit_s) begin
                        ins_out <= data_mem[req_idx_s];
                        flg_get <= 1'b1;
                        state_r <= RESP;
                     end else begin
                        wa_r      <= req_wa_s;
                        cnt_r     <= 3'd0;
                        ram_rd_en <= 1'b1;
                        ram_a     <= req_wa_s;
                        state_r   <= FILL;
                     end
                  end
               end
               FILL: begin
                  // cnt 0 with no read issued means a fill aborted by rdy: relaunch F0.
                  if (cnt_r == 3'd0 && !ram_rd_en) begin
                     ram_rd_en <= 1'b1;
                     ram_a     <= wa_r;
                  end else begin
                     case (cnt_r)
                        3'd1:    buf_r[7:0]   <= ram_din;
                        3'd2:    buf_r[15:8]  <= ram_din;
                        3'd3:    buf_r[23:16] <= ram_din;
                        default: buf_r        <= buf_r;
                     endcase
                     if (cnt_r == 3'd4) begin
                        ins_out <= fill_word_s;
                        flg_get <= 1'b1;
                        cnt_r   <= 3'd0;
                        state_r <= RESP;
                     end else begin
                        cnt_r     <= cnt_r + 3'd1;
                        ram_rd_en <= (cnt_r != 3'd3);
                        if (cnt_r != 3'd3) begin
                           ram_a <= next_a_s;
                        end
                     end
                  end
               end
               RESP: begin
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_mem_responder.sv
// Directed self-checking bench for if_mem_responder with a one-cycle-latency byte RAM model.
module tb_if_mem_responder;

   localparam int ADDR_W = 17;

   logic              clk;
   logic              rst;
   logic              rdy;
   logic              nd_ins;
   logic [31:0]       pc_fetch;
   logic              jal_reset;
   logic              flg_get;
   logic [31:0]       ins_out;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_a;
   logic [7:0]        ram_din;

   logic [7:0] ram [0:1023];
   int total;
   int pass_cnt;

   if_mem_responder #(.ADDR_W(ADDR_W), .IDX_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .nd_ins(nd_ins), .pc_fetch(pc_fetch),
      .jal_reset(jal_reset), .flg_get(flg_get), .ins_out(ins_out),
      .ram_rd_en(ram_rd_en), .ram_a(ram_a), .ram_din(ram_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM answers one cycle after the address is presented.
   always @(posedge clk) ram_din <= ram[ram_a[9:0]];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Issue a one-cycle request and measure the latency to flg_get.
   task automatic fetch(input logic [31:0] pc, input logic [31:0] exp_word,
                        input int exp_lat, input string tag);
      int   lat;
      logic saw_rd;
      nd_ins   = 1'b1;
      pc_fetch = pc;
      tick;
      nd_ins = 1'b0;
      saw_rd = ram_rd_en;
      lat    = 1;
      while (!flg_get && lat < 20) begin
         tick;
         lat++;
      end
      check(32'(lat), 32'(exp_lat), {tag, "_latency"});
      check(ins_out, exp_word, {tag, "_word"});
      if (exp_lat == 1) check({31'd0, saw_rd}, 32'd0, {tag, "_no_ram_read"});
      tick;
      check({31'd0, flg_get}, 32'd0, {tag, "_single_pulse"});
      check(ins_out, exp_word, {tag, "_hold"});
   endtask

   initial begin
      int pulses;
      int lat;
      total    = 0;
      pass_cnt = 0;
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[0]     = 8'h13; ram[1]     = 8'h05; ram[2]     = 8'h10; ram[3]     = 8'h00;
      ram[4]     = 8'hB3; ram[5]     = 8'h05; ram[6]     = 8'hB5; ram[7]     = 8'h00;
      ram[8]     = 8'h93; ram[9]     = 8'h02; ram[10]    = 8'h30; ram[11]    = 8'h00;
      ram[12'h100] = 8'hEF; ram[12'h101] = 8'h00; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;

      rst = 1'b0; rdy = 1'b1; nd_ins = 1'b0; pc_fetch = 32'd0; jal_reset = 1'b0;
      tick;
      tick;
      check({31'd0, flg_get}, 32'd0, "reset_flg_get");
      check(ins_out, 32'd0, "reset_ins_out");
      check({31'd0, ram_rd_en}, 32'd0, "reset_ram_rd_en");
      check(32'(ram_a), 32'd0, "reset_ram_a");
      rst = 1'b1;
      tick;

      // Cold miss at 0: address sequence and 6-cycle latency.
      nd_ins = 1'b1; pc_fetch = 32'h0;
      tick;
      nd_ins = 1'b0;
      check({31'd0, ram_rd_en}, 32'd1, "cold_f0_rd_en");
      check(32'(ram_a), 32'd0, "cold_f0_addr");
      tick;
      check(32'(ram_a), 32'd1, "cold_f1_addr");
      tick;
      check(32'(ram_a), 32'd2, "cold_f2_addr");
      tick;
      check(32'(ram_a), 32'd3, "cold_f3_addr");
      check({31'd0, ram_rd_en}, 32'd1, "cold_f3_rd_en");
      tick;
      check({31'd0, ram_rd_en}, 32'd0, "cold_f4_rd_en");
      check({31'd0, flg_get}, 32'd0, "cold_f4_no_flg");
      tick;
      check({31'd0, flg_get}, 32'd1, "cold_resp_flg");
      check(ins_out, 32'h00100513, "cold_resp_word");
      tick;
      check({31'd0, flg_get}, 32'd0, "cold_single_pulse");

      // Hit on the just-filled line.
      fetch(32'h0, 32'h00100513, 1, "hit0");

      // 0x100 aliases index 0: both fetches miss.
      fetch(32'h100, 32'h000000EF, 6, "alias100");
      fetch(32'h0,   32'h00100513, 6, "alias0");
      fetch(32'h103, 32'h000000EF, 6, "alias103_lowbits");

      // Redirect during F2 of a fetch at 0x8.
      nd_ins = 1'b1; pc_fetch = 32'h8;
      tick;
      nd_ins = 1'b0;
      tick;
      tick;
      check(32'(ram_a), 32'd10, "jal_f2_addr");
      jal_reset = 1'b1;
      tick;
      jal_reset = 1'b0;
      check({31'd0, ram_rd_en}, 32'd0, "jal_rd_en_low");
      check({31'd0, flg_get}, 32'd0, "jal_no_flg");
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (flg_get) pulses++;
      end
      check(32'(pulses), 32'd0, "jal_no_late_pulse");
      fetch(32'h8, 32'h00300293, 6, "after_jal");
      fetch(32'h8, 32'h00300293, 1, "after_jal_hit");

      // rdy low for 3 cycles starting in F1 of a fetch at 0x4.
      nd_ins = 1'b1; pc_fetch = 32'h4;
      tick;
      nd_ins = 1'b0;
      pc_fetch = 32'h8;
      tick;
      check(32'(ram_a), 32'd5, "rdy_f1_addr");
      rdy = 1'b0;
      tick;
      check({31'd0, ram_rd_en}, 32'd0, "rdy_abort_rd_en");
      tick;
      tick;
      rdy = 1'b1;
      tick;
      check({31'd0, ram_rd_en}, 32'd1, "rdy_restart_rd_en");
      check(32'(ram_a), 32'd4, "rdy_restart_addr");
      lat = 1;
      while (!flg_get && lat < 20) begin
         tick;
         lat++;
      end
      check(32'(lat), 32'd6, "rdy_restart_latency");
      check(ins_out, 32'h00B505B3, "rdy_restart_word");
      tick;
      check({31'd0, flg_get}, 32'd0, "rdy_single_pulse");

      // Asynchronous reset mid-fill, then verify the cache was invalidated.
      nd_ins = 1'b1; pc_fetch = 32'h10;
      tick;
      nd_ins = 1'b0;
      tick;
      #2;
      rst = 1'b0;
      #1;
      check({31'd0, ram_rd_en}, 32'd0, "async_rst_rd_en");
      check(32'(ram_a), 32'd0, "async_rst_addr");
      check(ins_out, 32'd0, "async_rst_ins_out");
      check({31'd0, flg_get}, 32'd0, "async_rst_flg");
      tick;
      rst = 1'b1;
      tick;
      fetch(32'h0, 32'h00100513, 6, "post_rst_miss");

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/if_mem_responder.md
Name: if_mem_responder

Overview:
- Memory-side responder for the instruction-fetch request interface (nd_ins/pc_fetch in, flg_get/instruction out).
- Serves 32-bit instruction words from the byte-wide main RAM using a pipelined 4-byte read.
- A direct-mapped instruction cache lets repeated fetches return in one cycle.
- Sits between the IF stage and the RAM port; read-only, it never writes RAM.

Parameters:
- ADDR_W, 17, RAM byte-address width.
- IDX_W, 6, cache index width (2^IDX_W one-word lines).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- rdy  input  1  ready; block pauses/aborts when low
- nd_ins  input  1  fetch request from IF, level
- pc_fetch  input  32  requested instruction address
- jal_reset  input  1  redirect; abort any fetch in progress
- flg_get  output  1  one-cycle pulse, ins_out valid
- ins_out  output  32  fetched instruction, little-endian
- ram_rd_en  output  1  RAM read issued this cycle
- ram_a  output  ADDR_W  RAM byte address
- ram_din  input  8  RAM read data, valid one cycle after ram_a

Behaviour:
- Reset (rst low, asynchronous):
  - flg_get=0, ins_out=0, ram_rd_en=0, ram_a=0.
  - State=IDLE, all cache valid bits cleared, byte counter=0.
- Address mapping:
  - Word address wa = {pc_fetch[ADDR_W-1:2], 2'b00}; pc_fetch[1:0] and bits above ADDR_W are ignored.
  - Cache index = pc_fetch[IDX_W+1:2]; tag = pc_fetch[ADDR_W-1:IDX_W+2].
- States: IDLE, FILL, RESP.
- IDLE:
  - Act only when nd_ins=1, rdy=1 and jal_reset=0.
  - Hit (valid and tag match): register ins_out=line, flg_get=1, go to RESP. Latency is 1 cycle.
  - Miss: latch wa, cnt=0, go to FILL.
- FILL (five cycles, F0..F4):
  - F0..F3: ram_rd_en=1, ram_a=wa+cnt for cnt 0..3.
  - F4: ram_rd_en=0.
  - At the end of F1..F4, capture ram_din into byte (cnt-1); byte0 goes to ins_out[7:0].
  - At the end of F4: write the word, tag and valid=1 into the line; set ins_out and flg_get=1; go to RESP.
  - Miss latency: flg_get high 6 cycles after the cycle nd_ins was sampled.
- RESP:
  - flg_get is high for exactly this cycle; ins_out holds until the next response.
  - Next state is IDLE. nd_ins is not sampled in RESP.
- flg_get is never high two consecutive cycles.
- jal_reset=1 (rdy high):
  - From any state: next state IDLE, flg_get=0 next cycle, ram_rd_en=0 next cycle.
  - The partial fill is discarded and the line is unmodified.
  - The cycle in which jal_reset=1 never starts a fetch.
- jal_reset in RESP: the pulse already asserted this cycle stands; there is no further pulse.
- rdy low:
  - IDLE/RESP: state frozen; flg_get forced 0 while rdy low.
  - FILL: fill aborted, ram_rd_en=0, captured bytes discarded; restart at F0 (cnt=0) when rdy returns.
- pc_fetch changes during FILL without jal_reset are ignored; the latched wa is served.
- Cache is never invalidated except by reset.

Test Plan:
- Cold miss: RAM[0..3]=13,05,10,00 hex; nd_ins=1, pc_fetch=0 -> ram_a=0,1,2,3 on consecutive cycles, flg_get pulses once 6 cycles later, ins_out=0x00100513.
- Hit: same request repeated after RESP -> flg_get next cycle, ins_out=0x00100513, ram_rd_en stays 0.
- Aliasing (IDX_W=6): fetch 0x100 (RAM 0x100..0x103=EF,00,00,00) -> miss, ins_out=0x000000EF; refetch 0 -> miss again, 0x00100513.
- jal_reset asserted in F2 of a fetch at 0x8 -> no flg_get, ram_rd_en low next cycle; later fetch at 0x8 misses and refills correctly.
- rdy low for 3 cycles during F1 -> no capture, restart at ram_a=wa; correct word; flg_get 6 cycles after rdy returns.
- rst low mid-fill -> outputs 0 without a clock edge; after release, fetch of 0 misses, proving the valid bits were cleared.
